alu_nibble_sequencer: RTL and testbench

Multi-cycle controller that runs wide add, subtract, OR and AND operations on the team's 4-bit combinational `alu`. It owns the driving side of the ALU's `operation_i`/`operand*_i`/`carry_in` interface. Each accepted command is split into 4-bit nibbles, and one nibble goes through the ALU per cycle, least significant first, with the ALU's `carry_out` fed back as the next nibble's carry/borrow. Commands and responses use valid/ready handshakes, so the block sits between a register-level datapath and a single shared `alu` instance.

---
 rtl/alu_nibble_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Drives a shared 4-bit combinational ALU one nibble per cycle, least
// significant nibble first. This turns a W-bit ADD/SUB/OR/AND command into
// NIBBLES ALU passes. The ALU carry/borrow out of each nibble is fed back as
// the carry/borrow into the next nibble. Commands and responses use
// valid/ready handshakes.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [4*NIBBLES-1:0] cmd_a_i,
    input  logic [4*NIBBLES-1:0] cmd_b_i,
    input  logic                 cmd_carry_i,

    output logic [1:0]           alu_operation_o,
    output logic [3:0]           alu_operand1_o,
    output logic [3:0]           alu_operand2_o,
    output logic                 alu_carry_in_o,
    input  logic [3:0]           alu_result_i,
    input  logic                 alu_carry_out_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [4*NIBBLES-1:0] rsp_result_o,
    output logic                 rsp_carry_o,
    output logic                 rsp_zero_o
);

    localparam int W = 4 * NIBBLES;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Index of the final nibble; 5 bits covers the legal range 1..16.
    localparam logic [4:0] LAST_IDX = 5'(NIBBLES - 1);

    logic [1:0]   state;
    logic [4:0]   idx;
    logic [1:0]   op_p0;

    // Operands are pre-shifted so that the next nibble is always in bits [3:0].
    logic [W-1:0] a_sh_p0;
    logic [W-1:0] b_sh_p0;

    // Result nibbles enter at the top and move down. After NIBBLES captures,
    // nibble 0 is in bits [3:0].
    logic [W-1:0] acc_p1;
    logic [W-1:0] acc_next;

    logic         accept;
    logic         rsp_fire;
    logic         last_nib;
    logic         chain_carry;

    // Shifts the accumulator down one nibble and inserts the new nibble at the top.
    function automatic logic [W-1:0] shift_in_nibble(input logic [W-1:0] acc,
                                                     input logic [3:0]   nib);
        logic [W-1:0] ext;
        ext = W'(nib);
        return (acc >> 4) | (ext << (W - 4));
    endfunction

    // Only ADD (00) and SUB (01) use a carry chain. OR and AND force it to 0.
    function automatic logic gate_carry(input logic [1:0] op, input logic c);
        return ~op[1] & c;
    endfunction

    assign accept      = (state == ST_IDLE) && cmd_valid_i && cmd_ready_o;
    assign rsp_fire    = rsp_valid_o && rsp_ready_i;
    assign last_nib    = (state == ST_RUN) && (idx == LAST_IDX);
    assign acc_next    = shift_in_nibble(acc_p1, alu_result_i);
    assign chain_carry = gate_carry(op_p0, alu_carry_out_i);

    // FSM, ALU drive and response registers. Reset abandons any command in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            idx             <= 5'd0;
            op_p0           <= 2'b00;
            cmd_ready_o     <= 1'b0;
            alu_operation_o <= 2'b00;
            alu_operand1_o  <= 4'h0;
            alu_operand2_o  <= 4'h0;
            alu_carry_in_o  <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_result_o    <= '0;
            rsp_carry_o     <= 1'b0;
            rsp_zero_o      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (accept) begin
                        state           <= ST_RUN;
                        cmd_ready_o     <= 1'b0;
                        idx             <= 5'd0;
                        op_p0           <= cmd_op_i;
                        alu_operation_o <= cmd_op_i;
                        alu_operand1_o  <= cmd_a_i[3:0];
                        alu_operand2_o  <= cmd_b_i[3:0];
                        alu_carry_in_o  <= gate_carry(cmd_op_i, cmd_carry_i);
                    end
                end

                // RUN: each edge captures nibble idx and presents nibble idx+1.
                ST_RUN: begin
                    if (last_nib) begin
                        state           <= ST_DONE;
                        alu_operation_o <= 2'b00;
                        alu_operand1_o  <= 4'h0;
                        alu_operand2_o  <= 4'h0;
                        alu_carry_in_o  <= 1'b0;
                        rsp_valid_o     <= 1'b1;
                        rsp_result_o    <= acc_next;
                        rsp_carry_o     <= chain_carry;
                        rsp_zero_o      <= ~|acc_next;
                    end else begin
                        idx            <= idx + 5'd1;
                        alu_operand1_o <= a_sh_p0[3:0];
                        alu_operand2_o <= b_sh_p0[3:0];
                        alu_carry_in_o <= chain_carry;
                    end
                end

                // DONE: the response is held unchanged until the consumer takes it.
                ST_DONE: begin
                    if (rsp_fire) begin
                        state       <= ST_IDLE;
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    cmd_ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Operand shifters and result accumulator. These are data only, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            a_sh_p0 <= cmd_a_i >> 4;
            b_sh_p0 <= cmd_b_i >> 4;
        end else if (state == ST_RUN) begin
            a_sh_p0 <= a_sh_p0 >> 4;
            b_sh_p0 <= b_sh_p0 >> 4;
            acc_p1  <= acc_next;
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer (NIBBLES = 4). It uses a
// behavioural 4-bit ALU, directed vectors and hand-written backpressure and
// reset sequences.
module tb_alu_nibble_sequencer;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_carry;
    logic [1:0]   alu_operation;
    logic [3:0]   alu_operand1;
    logic [3:0]   alu_operand2;
    logic         alu_carry_in;
    logic [3:0]   alu_result;
    logic         alu_carry_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_zero;

    logic [4:0]   alu_tmp;

    int checks = 0;
    int errors = 0;

    // Values observed while a command is running.
    int           lat_seen;
    logic [3:0]   cseq_seen;
    logic [W-1:0] op1_seen;
    logic [W-1:0] op2_seen;
    logic [1:0]   opc_seen;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic [3:0]   cseq;   // bit k = alu_carry_in during nibble k
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_op_i        (cmd_op),
        .cmd_a_i         (cmd_a),
        .cmd_b_i         (cmd_b),
        .cmd_carry_i     (cmd_carry),
        .alu_operation_o (alu_operation),
        .alu_operand1_o  (alu_operand1),
        .alu_operand2_o  (alu_operand2),
        .alu_carry_in_o  (alu_carry_in),
        .alu_result_i    (alu_result),
        .alu_carry_out_i (alu_carry_out),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_result_o    (rsp_result),
        .rsp_carry_o     (rsp_carry),
        .rsp_zero_o      (rsp_zero)
    );

    // Behavioural 4-bit ALU. Bit 4 of the 5-bit result is carry for ADD and borrow for SUB.
    always_comb begin
        alu_tmp = 5'd0;
        case (alu_operation)
            2'b00:   alu_tmp = {1'b0, alu_operand1} + {1'b0, alu_operand2} + 5'(alu_carry_in);
            2'b01:   alu_tmp = {1'b0, alu_operand1} - {1'b0, alu_operand2} - 5'(alu_carry_in);
            2'b10:   alu_tmp = {1'b0, alu_operand1 | alu_operand2};
            default: alu_tmp = {1'b0, alu_operand1 & alu_operand2};
        endcase
        alu_result    = alu_tmp[3:0];
        alu_carry_out = alu_tmp[4];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Waits for cmd_ready, presents one command and returns just after the accept edge.
    task automatic start_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'(1));
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_carry = cin;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        // Put junk on the command bus. The DUT must use only its registered copy.
        cmd_op    = ~op;
        cmd_a     = 16'hDEAD;
        cmd_b     = 16'hBEEF;
        cmd_carry = ~cin;
    endtask

    // Samples each cycle until rsp_valid is seen, recording the nibble drive.
    task automatic wait_rsp();
        int n;
        n = 0;
        lat_seen  = 0;
        cseq_seen = 4'h0;
        op1_seen  = '0;
        op2_seen  = '0;
        opc_seen  = 2'b00;
        while (n < 20) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (lat_seen < NIB) begin
                cseq_seen[lat_seen]       = alu_carry_in;
                op1_seen[4*lat_seen +: 4] = alu_operand1;
                op2_seen[4*lat_seen +: 4] = alu_operand2;
                if (lat_seen == 0) opc_seen = alu_operation;
            end
            lat_seen++;
            n++;
        end
        check("rsp_valid_wait", 32'(rsp_valid), 32'(1));
    endtask

    // Completes the response handshake and checks that rsp_valid drops.
    task automatic finish_rsp(input string name);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid_drop"}, 32'(rsp_valid), 32'(0));
        check({name, "_ready_back"}, 32'(cmd_ready), 32'(1));
    endtask

    task automatic run_vec(input vec_t v, input string name);
        start_cmd(v.op, v.a, v.b, v.cin);
        wait_rsp();
        check({name, "_latency"},  32'(lat_seen),   32'(NIB));
        check({name, "_result"},   32'(rsp_result), 32'(v.res));
        check({name, "_carry"},    32'(rsp_carry),  32'(v.carry));
        check({name, "_zero"},     32'(rsp_zero),   32'(v.zero));
        check({name, "_cin_seq"},  32'(cseq_seen),  32'(v.cseq));
        check({name, "_op1_seq"},  32'(op1_seen),   32'(v.a));
        check({name, "_op2_seq"},  32'(op2_seen),   32'(v.b));
        check({name, "_opcode"},   32'(opc_seen),   32'(v.op));
        check({name, "_alu_idle"}, 32'({alu_operation, alu_operand1, alu_operand2, alu_carry_in}), 32'(0));
        check({name, "_busy"},     32'(cmd_ready),  32'(0));
        finish_rsp(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        //                op     a         b         cin   res       c     z     cseq
        vecs[0] = '{2'b00, 16'h5A3C, 16'h1234, 1'b0, 16'h6C70, 1'b0, 1'b0, 4'b0010};
        vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b1110};
        vecs[2] = '{2'b00, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 4'b1111};
        vecs[3] = '{2'b01, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 1'b0, 4'b1110};
        vecs[4] = '{2'b01, 16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, 1'b0, 4'b1111};
        vecs[5] = '{2'b01, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 4'b0000};
        vecs[6] = '{2'b10, 16'hF0F0, 16'h0F0F, 1'b1, 16'hFFFF, 1'b0, 1'b0, 4'b0000};
        vecs[7] = '{2'b11, 16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b0, 1'b1, 4'b0000};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_carry = 1'b0;
        rsp_ready = 1'b0;

        // Values held during reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_bits",  32'({rsp_result, rsp_carry, rsp_zero}), 32'(0));
        check("rst_alu_bits",  32'({alu_operation, alu_operand1, alu_operand2, alu_carry_in}), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'(1));

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure with a second command waiting
        start_cmd(2'b00, 16'h1111, 16'h2222, 1'b0);
        wait_rsp();
        check("bp_first_result", 32'(rsp_result), 32'(16'h3333));
        cmd_op    = 2'b01;
        cmd_a     = 16'h0003;
        cmd_b     = 16'h0001;
        cmd_carry = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid",  32'(rsp_valid),  32'(1));
            check("bp_hold_result", 32'({rsp_result, rsp_carry, rsp_zero}), 32'({16'h3333, 1'b0, 1'b0}));
            check("bp_hold_ready",  32'(cmd_ready),  32'(0));
            check("bp_hold_alu",    32'(alu_operation), 32'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_after_hs_valid", 32'(rsp_valid), 32'(0));
        check("bp_after_hs_ready", 32'(cmd_ready), 32'(1));
        check("bp_not_yet_run",    32'(alu_operation), 32'(0));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_second_started_op",  32'(alu_operation), 32'(2'b01));
        check("bp_second_started_nib", 32'(alu_operand1),  32'(4'h3));
        wait_rsp();
        check("bp_second_result", 32'({rsp_result, rsp_carry, rsp_zero}), 32'({16'h0002, 1'b0, 1'b0}));
        finish_rsp("bp_second");

        // Reset in the middle of a command
        start_cmd(2'b00, 16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rsp",   32'({rsp_valid, rsp_result, rsp_carry, rsp_zero}), 32'(0));
        check("midrst_alu",   32'({alu_operation, alu_operand1, alu_operand2, alu_carry_in}), 32'(0));
        check("midrst_ready", 32'(cmd_ready), 32'(0));
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("midrst_no_rsp", 32'(pulses), 32'(0));
        check("midrst_ready_back", 32'(cmd_ready), 32'(1));
        run_vec('{2'b00, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b0000}, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
